// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: stalls the pipeline for LATENCY cycles per access.
// Optional sticky error flag built when DATA_MEM_RESPONDER_ERR_EN is defined.
module data_mem_responder #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 32
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam bit          SINGLE = (LATENCY == 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [3:0]    count;
  logic          op_write;
  logic          op_oor;
  logic [AW-1:0] op_idx;
  logic [31:0]   op_data;
  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          capture;
  logic          do_access;
  logic          oor_in;
  logic [AW-1:0] idx_in;
  logic          acc_write;
  logic          acc_oor;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_data;

  // With LATENCY==1 the access happens on the capture edge, so it must use
  // the live inputs instead of the (not yet loaded) latched request.
  always_comb begin
    req       = MemRead_i | MemWrite_i;
    stall_o   = req & (state != DONE);
    capture   = (state == IDLE) & req;
    oor_in    = |Addr_i[31:AW+2];
    idx_in    = Addr_i[AW+1:2];
    do_access = (capture & SINGLE) | ((state == BUSY) & (count == 4'd1));
    acc_write = capture ? MemWrite_i  : op_write;
    acc_oor   = capture ? oor_in      : op_oor;
    acc_idx   = capture ? idx_in      : op_idx;
    acc_data  = capture ? WriteData_i : op_data;
  end

  // BUSY holds LATENCY-1 cycles: the access fires on the edge where the
  // counter steps from 1 to 0, giving LATENCY stalled cycles including IDLE.
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      state      <= IDLE;
      count      <= '0;
      ReadData_o <= '0;
    end else begin
      if (do_access && !acc_write)
        ReadData_o <= acc_oor ? '0 : mem[acc_idx];
      case (state)
        IDLE: if (req) begin
          count <= LAT_M1;
          state <= SINGLE ? DONE : BUSY;
        end
        BUSY: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_i && capture) begin
      op_write <= MemWrite_i;
      op_oor   <= oor_in;
      op_idx   <= idx_in;
      op_data  <= WriteData_i;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (start_i && do_access && acc_write && !acc_oor)
      mem[acc_idx] <= acc_data;
  end

`ifdef DATA_MEM_RESPONDER_ERR_EN
  logic err_in;
  assign err_in = (MemRead_i & MemWrite_i) | oor_in | (Addr_i[1:0] != 2'b00);

  always_ff @(posedge clk_i) begin
    if (!start_i)
      err_o <= 1'b0;
    else if (capture && err_in)
      err_o <= 1'b1;
  end
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^Addr_i[1:0];
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=3 and a LATENCY=1 instance checked
// every cycle against a transaction-timeline model, plus literal pins.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        start_n = 1'b0;
  logic [1:0]  rd = '0;
  logic [1:0]  wr = '0;
  logic [31:0] addr [2] = '{32'd0, 32'd0};
  logic [31:0] wdata [2] = '{32'd0, 32'd0};
  logic [31:0] rdata [2];
  logic [1:0]  stall;
  logic [1:0]  err;

  int errors = 0;
  int checks = 0;
  bit armed = 1'b0;

`ifdef DATA_MEM_RESPONDER_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(3), .DEPTH(32)) u_lat3 (
    .clk_i(clk), .start_i(start_n), .MemRead_i(rd[0]), .MemWrite_i(wr[0]),
    .Addr_i(addr[0]), .WriteData_i(wdata[0]), .ReadData_o(rdata[0]),
    .stall_o(stall[0]), .err_o(err[0]));

  data_mem_responder #(.LATENCY(1), .DEPTH(32)) u_lat1 (
    .clk_i(clk), .start_i(start_n), .MemRead_i(rd[1]), .MemWrite_i(wr[1]),
    .Addr_i(addr[1]), .WriteData_i(wdata[1]), .ReadData_o(rdata[1]),
    .stall_o(stall[1]), .err_o(err[1]));

  // Timeline model: a request accepted at edge t commits at edge t+LATENCY-1,
  // the cycle after the commit has stall low, and nothing is accepted then.
  int unsigned lat [2] = '{3, 1};
  logic [31:0] m_mem [2][32];
  logic [31:0] m_rd [2] = '{32'd0, 32'd0};
  bit          m_err [2] = '{1'b0, 1'b0};
  bit          pending [2] = '{1'b0, 1'b0};
  bit          in_done [2] = '{1'b0, 1'b0};
  int unsigned commit_cyc [2];
  bit          c_wr [2];
  bit          c_oor [2];
  int unsigned c_idx [2];
  logic [31:0] c_data [2];
  int unsigned cyc = 0;

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!start_n) begin
        pending[d] = 1'b0;
        in_done[d] = 1'b0;
        m_rd[d]    = 32'd0;
        m_err[d]   = 1'b0;
      end else if (in_done[d]) begin
        in_done[d] = 1'b0;
      end else begin
        if (!pending[d] && (rd[d] || wr[d])) begin
          pending[d]    = 1'b1;
          commit_cyc[d] = cyc + lat[d] - 1;
          c_wr[d]       = wr[d];
          c_oor[d]      = addr[d] >= 32'd128;
          c_idx[d]      = (addr[d] / 4) % 32;
          c_data[d]     = wdata[d];
          if (ERR_ON && ((rd[d] && wr[d]) || addr[d] >= 32'd128 || addr[d] % 4 != 0))
            m_err[d] = 1'b1;
        end
        if (pending[d] && cyc == commit_cyc[d]) begin
          if (c_wr[d]) begin
            if (!c_oor[d]) m_mem[d][c_idx[d]] = c_data[d];
          end else begin
            m_rd[d] = c_oor[d] ? 32'd0 : m_mem[d][c_idx[d]];
          end
          pending[d] = 1'b0;
          in_done[d] = 1'b1;
        end
      end
    end
    if (!start_n) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (stall[d] !== ((rd[d] | wr[d]) & ~in_done[d])) begin
          errors++;
          $display("FAIL model_stall dut%0d t=%0t got=%b exp=%b", d, $time, stall[d],
                   (rd[d] | wr[d]) & ~in_done[d]);
        end
        checks++;
        if (rdata[d] !== m_rd[d]) begin
          errors++;
          $display("FAIL model_rdata dut%0d t=%0t got=%h exp=%h", d, $time, rdata[d], m_rd[d]);
        end
        checks++;
        if (err[d] !== m_err[d]) begin
          errors++;
          $display("FAIL model_err dut%0d t=%0t got=%b exp=%b", d, $time, err[d], m_err[d]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One access from the IDLE cycle through DONE; returns stalled cycles and DONE data.
  task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] data, output int n_stall, output logic [31:0] done_rd);
    n_stall = 0;
    done_rd = '0;
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = data;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall[d]) break;
      n_stall++;
    end
    if (n_stall >= 40) begin
      errors++;
      checks++;
      $display("FAIL timeout dut%0d stall never dropped", d);
    end
    done_rd = rdata[d];
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  int          ns;
  logic [31:0] v;

  initial begin
    repeat (2) @(posedge clk);
    #1 start_n = 1'b1;
    @(negedge clk);
    chk("reset_rdata", rdata[0], 32'd0);
    chk("reset_stall", {31'd0, stall[0]}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      for (int d = 0; d < 2; d++)
        access(d, 1'b0, 1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i * 32'h111), ns, v);

    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ns, v);
    chk("wr_stall_cycles_l3", 32'(ns), 32'd3);
    access(0, 1'b1, 1'b0, 32'h10, 32'd0, ns, v);
    chk("rd_stall_cycles_l3", 32'(ns), 32'd3);
    chk("rd_deadbeef", v, 32'hDEADBEEF);

    access(1, 1'b0, 1'b1, 32'h14, 32'hCAFEF00D, ns, v);
    chk("wr_stall_cycles_l1", 32'(ns), 32'd1);
    access(1, 1'b1, 1'b0, 32'h14, 32'd0, ns, v);
    chk("b2b_wr_rd", v, 32'hCAFEF00D);

    // continuous read on the single-cycle instance, address moved after first DONE
    rd[1] = 1'b1; addr[1] = 32'h4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("l1_stall_pat%0d", i), {31'd0, stall[1]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i == 1) begin
        chk("l1_rd_w1", rdata[1], 32'h1000_0111);
        @(posedge clk); #1 addr[1] = 32'h8;
      end
      if (i == 3) chk("l1_rd_w2", rdata[1], 32'h1000_0222);
    end
    @(posedge clk); #1 rd[1] = 1'b0;

    // inputs changed mid-access are ignored
    wr[0] = 1'b1; addr[0] = 32'hC; wdata[0] = 32'h0BADF00D;
    @(posedge clk); #1;
    addr[0] = 32'h0; wdata[0] = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1 wr[0] = 1'b0;
    access(0, 1'b1, 1'b0, 32'h0, 32'd0, ns, v);
    chk("busy_ignore_w0", v, 32'h1000_0000);
    access(0, 1'b1, 1'b0, 32'hC, 32'd0, ns, v);
    chk("busy_ignore_w3", v, 32'h0BADF00D);

    // reset during the second BUSY cycle aborts the write
    wr[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'h12345678;
    @(posedge clk);
    @(posedge clk); #1;
    start_n = 1'b0; wr[0] = 1'b0;
    @(posedge clk); #1 start_n = 1'b1;
    @(negedge clk);
    chk("abort_rdata", rdata[0], 32'd0);
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 32'h8, 32'd0, ns, v);
    chk("abort_mem_kept", v, 32'h1000_0222);

    access(0, 1'b1, 1'b0, 32'h200, 32'd0, ns, v);
    chk("oor_rd_zero", v, 32'd0);
    chk("oor_err", {31'd0, err[0]}, {31'd0, ERR_ON});
    access(0, 1'b1, 1'b0, 32'h4, 32'd0, ns, v);
    chk("err_held", {31'd0, err[0]}, {31'd0, ERR_ON});

    access(0, 1'b1, 1'b1, 32'h0, 32'hA5A5A5A5, ns, v);
    access(0, 1'b1, 1'b0, 32'h0, 32'd0, ns, v);
    chk("rw_both_is_write", v, 32'hA5A5A5A5);

    access(1, 1'b1, 1'b0, 32'h9, 32'd0, ns, v);
    chk("misaligned_rd", v, 32'h1000_0222);
    chk("misaligned_err", {31'd0, err[1]}, {31'd0, ERR_ON});
    access(1, 1'b0, 1'b1, 32'h80, 32'h77777777, ns, v);
    access(1, 1'b1, 1'b0, 32'h0, 32'd0, ns, v);
    chk("oor_wr_dropped", v, 32'h1000_0000);

    start_n = 1'b0;
    @(posedge clk); #1 start_n = 1'b1;
    @(negedge clk);
    chk("reset_clears_err", {30'd0, err}, 32'd0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
